// File: rtl/aes128_dec_pkg.sv
// aes128_dec_pkg: AES-128 constants, S-box tables and GF(2^8) helpers shared by encryptor and decryptor
package aes128_dec_pkg;
   localparam int NR = 10;
   typedef enum logic [1:0] {IDLE, ADDKEY, ROUND} state_t;
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
   localparam logic [1:NR][7:0] RCON = 80'h01020408102040801b36;
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = xtime(x);
      end
      return p;
   endfunction
   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one inverse cipher round; key is added before InvMixColumns so rk[] needs no transform
module aes_inv_round
   import aes128_dec_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         final_round,
   output logic [127:0] state_out
);
   logic [7:0] a [16];
   logic [7:0] m [16];
   always_comb begin
      for (int k = 0; k < 16; k++)
         a[k] = INV_SBOX[state_in[127-8*(4*((k/4 - k%4 + 4) % 4) + k%4) -: 8]] ^ round_key[127-8*k -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            m[4*c+r] = gmul(a[4*c+r], 8'h0e) ^ gmul(a[4*c+(r+1)%4], 8'h0b)
                     ^ gmul(a[4*c+(r+2)%4], 8'h0d) ^ gmul(a[4*c+(r+3)%4], 8'h09);
      for (int k = 0; k < 16; k++)
         state_out[127-8*k -: 8] = final_round ? a[k] : m[k];
   end
endmodule

// File: rtl/key_expansion.sv
// key_expansion: combinational AES-128 key schedule, rk[0] is the cipher key itself
module key_expansion
   import aes128_dec_pkg::*;
(
   input  logic [127:0]          key,
   output logic [0:NR][127:0]    rk
);
   logic [31:0] w [4*(NR+1)];
   always_comb begin
      for (int i = 0; i < 4; i++)
         w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 4*(NR+1); i++)
         w[i] = w[i-4] ^ (i % 4 == 0 ? sub_word({w[i-1][23:0], w[i-1][31:24]}) ^ {RCON[i/4], 24'h0} : w[i-1]);
      for (int r = 0; r <= NR; r++)
         rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   end
endmodule

// File: rtl/aes128_dec_top.sv
// aes128_dec_top: iterative AES-128 decryptor, one round per clock, 11 edges from accept to done
module aes128_dec_top
   import aes128_dec_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic [127:0] plaintext,
   output logic         busy,
   output logic         done
);
   state_t st, nxt;
   logic [127:0] ct_q, key_q, s, rnd_out;
   logic [3:0] cnt;
   logic [0:NR][127:0] rk;
   logic accept, fin;
   key_expansion u_kx (.key(key_q), .rk(rk));
   aes_inv_round u_rnd (.state_in(s), .round_key(rk[cnt]), .final_round(fin), .state_out(rnd_out));
   always_ff @(posedge clk or posedge rst)
      if (rst)
         st <= IDLE;
      else
         st <= nxt;
   // busy stays high through the done cycle, so IDLE ignores start until it falls
   always_comb begin
      accept = st == IDLE && start && !busy;
      fin = st == ROUND && cnt == 4'd0;
      nxt = accept ? ADDKEY : st == ADDKEY ? ROUND : (st == ROUND && !fin) ? ROUND : IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ct_q <= '0;
         key_q <= '0;
         s <= '0;
         cnt <= '0;
         plaintext <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         if (accept) begin
            ct_q <= ciphertext;
            key_q <= key;
         end
         if (st == ADDKEY) begin
            s <= ct_q ^ rk[NR];
            cnt <= 4'(NR - 1);
         end
         if (st == ROUND) begin
            s <= rnd_out;
            cnt <= fin ? cnt : cnt - 4'd1;
         end
         if (fin)
            plaintext <= rnd_out;
         done <= fin;
         busy <= accept || (busy && !done);
      end
   end
endmodule

// File: tb/tb_aes128_dec_top.sv
// tb_aes128_dec_top: FIPS vectors, protocol corner cases and random round-trips against a cycle-level model
module tb_aes128_dec_top;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [127:0] ciphertext = '0, key = '0;
   logic [127:0] plaintext;
   logic busy, done;
   int total = 0, bad = 0;
   logic [7:0] sb [256];
   logic [7:0] isb [256];
   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

   aes128_dec_top dut (.clk(clk), .rst(rst), .start(start), .ciphertext(ciphertext), .key(key),
                       .plaintext(plaintext), .busy(busy), .done(done));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [129:0] act, input logic [129:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [1407:0] expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0] rc;
      logic [1407:0] o;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]] ^ rc, sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
            rc = gm(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
      return o;
   endfunction

   function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
      logic [1407:0] ks;
      logic [7:0] s [16];
      logic [7:0] n [16];
      logic [127:0] v;
      ks = expand(k);
      v = p ^ ks[1407 -: 128];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sb[v[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) n[4*c+q] = s[4*((c+q)%4)+q];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
               s[4*c+q] = (r == 10) ? n[4*c+q] : gm(n[4*c+q], 8'h02) ^ gm(n[4*c+(q+1)%4], 8'h03)
                                                ^ n[4*c+(q+2)%4] ^ n[4*c+(q+3)%4];
         for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
         v ^= ks[1407-128*r -: 128];
      end
      return v;
   endfunction

   function automatic logic [127:0] dec(input logic [127:0] ct, input logic [127:0] k);
      logic [1407:0] ks;
      logic [7:0] s [16];
      logic [7:0] n [16];
      logic [127:0] v;
      ks = expand(k);
      v = ct ^ ks[127:0];
      for (int r = 9; r >= 0; r--) begin
         for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) n[4*c+q] = isb[s[4*((c-q+4)%4)+q]];
         for (int i = 0; i < 16; i++) v[127-8*i -: 8] = n[i];
         v ^= ks[1407-128*r -: 128];
         if (r > 0) begin
            for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
            for (int c = 0; c < 4; c++)
               for (int q = 0; q < 4; q++)
                  n[4*c+q] = gm(s[4*c+q], 8'h0e) ^ gm(s[4*c+(q+1)%4], 8'h0b)
                           ^ gm(s[4*c+(q+2)%4], 8'h0d) ^ gm(s[4*c+(q+3)%4], 8'h09);
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = n[i];
         end
      end
      return v;
   endfunction

   // Cycle model: accepts when idle during the previous cycle, done 11 edges later, idle one edge after that.
   int cyc = 0, acc = 0;
   logic m_active = 1'b0, m_busy = 1'b0, m_done = 1'b0, prev;
   logic [127:0] m_pt = '0, m_pend = '0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_pt = '0;
      end else begin
         cyc++;
         prev = m_busy;
         if (m_active && cyc == acc + 12) m_active = 1'b0;
         m_done = m_active && cyc == acc + 11;
         if (m_done) m_pt = m_pend;
         if (!prev && start) begin
            m_active = 1'b1;
            acc = cyc;
            m_pend = dec(ciphertext, key);
         end
         m_busy = m_active;
      end
   end

   always @(negedge clk)
      chk("cycle busy/done/plaintext", {busy, done, plaintext}, {m_busy, m_done, m_pt});

   task automatic run_block(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] exp, input string nm);
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      ciphertext = ct;
      key = k;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk({nm, " latency"}, 130'(n), 130'(11));
      chk({nm, " result"}, 130'(plaintext), 130'(exp));
   endtask

   initial begin
      int n, nd;
      logic [127:0] p, k;
      for (int a = 0; a < 256; a++) begin
         logic [7:0] y;
         y = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gm(8'(a), 8'(b)) == 8'h01) y = 8'(b);
         sb[a] = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
         isb[sb[a]] = 8'(a);
      end
      chk("model sbox[00]", 130'(sb[0]), 130'(8'h63));
      chk("model sbox[53]", 130'(sb[8'h53]), 130'(8'hed));
      chk("model enc C.1", 130'(enc(P1, K1)), 130'(C1));
      chk("model enc B", 130'(enc(PB, KB)), 130'(CB));
      chk("model dec C.1", 130'(dec(C1, K1)), 130'(P1));
      repeat (3) @(negedge clk);
      chk("reset outputs", {busy, done, plaintext}, 130'(0));
      rst = 1'b0;
      run_block(C1, K1, P1, "C.1");
      run_block(CB, KB, PB, "B back-to-back");
      run_block(C1, K1, P1, "C.1 back-to-back");
      // start held high with the B vector throughout the C.1 operation
      @(negedge clk);
      ciphertext = C1;
      key = K1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ciphertext = CB;
      key = KB;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("hold latency", 130'(n), 130'(11));
      chk("hold result", 130'(plaintext), 130'(P1));
      @(negedge clk);
      chk("start in done cycle ignored", 130'(busy), 130'(0));
      @(negedge clk);
      chk("start after done accepted", 130'(busy), 130'(1));
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("hold second latency", 130'(n), 130'(11));
      chk("hold second result", 130'(plaintext), 130'(PB));
      // reset five edges after acceptance
      @(negedge clk);
      ciphertext = C1;
      key = K1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(posedge clk);
      rst = 1'b1;
      #1;
      chk("reset abort outputs", {busy, done, plaintext}, 130'(0));
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (15) begin
         @(negedge clk);
         nd += int'(done);
      end
      chk("no done after abort", 130'(nd), 130'(0));
      run_block(C1, K1, P1, "C.1 after reset");
      for (int i = 0; i < 1000; i++) begin
         p = {$urandom(), $urandom(), $urandom(), $urandom()};
         k = {$urandom(), $urandom(), $urandom(), $urandom()};
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         run_block(enc(p, k), k, p, "random round-trip");
      end
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
